// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 binary multiplier with a radix-4 Booth core.
// Operands are captured on the input handshake. Special operands resolve
// directly to DONE. Normal operands pass through N_ITER Booth cycles and one
// rounding cycle before the result is presented. Subnormals flush to zero.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   nv
);

    localparam int W      = EXP_W + FRC_W + 1;
    localparam int SIG_W  = FRC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int N_ITER = (SIG_W + 1) / 2;
    localparam int YE     = 2 * N_ITER;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int XW     = EXP_W + 2;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_ITER - 1);
    localparam logic signed [XW-1:0] EXP_LIM  = XW'(2 ** EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_DONE} state_e;
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    state_e              state_q;
    logic                in_ready_q, out_valid_q;
    logic [W-1:0]        fp_z_q;
    logic                ovrf_q, udrf_q, nv_q;
    logic                sign_q;
    logic [EXP_W-1:0]    ex_q, ey_q;
    rmode_e              mode_q;
    logic [PROD_W-1:0]   m_q;
    logic [YE-1:0]       ybits_q;
    logic                yprev_q;
    logic [PROD_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;

    // Operand field views
    logic [EXP_W-1:0] ex_in, ey_in;
    logic [FRC_W-1:0] fx_in, fy_in;
    logic             sign_in;
    assign ex_in   = fp_X[W-2 -: EXP_W];
    assign ey_in   = fp_Y[W-2 -: EXP_W];
    assign fx_in   = fp_X[FRC_W-1:0];
    assign fy_in   = fp_Y[FRC_W-1:0];
    assign sign_in = fp_X[W-1] ^ fp_Y[W-1];

    logic             is_special_d, sp_nv_d;
    logic [W-1:0]     sp_z_d;
    logic [PROD_W-1:0] m_init_d, corr_d;
    logic [YE-1:0]    y_init_d;
    rmode_e           mode_in_d;

    // Classify incoming operands and build the special result and Booth seeds
    always_comb begin
        logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sp_z_d       = '0;
        x_zero       = (ex_in == '0);
        y_zero       = (ey_in == '0);
        x_inf        = (&ex_in) && (fx_in == '0);
        y_inf        = (&ey_in) && (fy_in == '0);
        x_nan        = (&ex_in) && (fx_in != '0);
        y_nan        = (&ey_in) && (fy_in != '0);
        sp_nv_d      = x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf);
        is_special_d = x_zero || y_zero || x_inf || y_inf || x_nan || y_nan;
        if (sp_nv_d)
            sp_z_d = QNAN;
        else if (x_inf || y_inf)
            sp_z_d = {sign_in, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        else
            sp_z_d = {sign_in, {(W-1){1'b0}}};

        // An unsigned multiplier whose top Booth bit is set reads as negative;
        // seed the accumulator with the compensating multiple.
        m_init_d  = PROD_W'({1'b1, fx_in});
        y_init_d  = YE'({1'b1, fy_in});
        corr_d    = y_init_d[YE-1] ? (m_init_d << YE) : '0;
        mode_in_d = (r_mode > 3'b100) ? RM_RNE : rmode_e'(r_mode);
    end

    logic [PROD_W-1:0] pp_d;

    // Radix-4 Booth partial product for the current digit
    always_comb begin
        pp_d = '0;
        case ({ybits_q[1:0], yprev_q})
            3'b001, 3'b010: pp_d = m_q;
            3'b011:         pp_d = m_q << 1;
            3'b100:         pp_d = -(m_q << 1);
            3'b101, 3'b110: pp_d = -m_q;
            default:        pp_d = '0;
        endcase
    end

    logic [W-1:0] rnd_z_d;
    logic         rnd_ovf_d, rnd_unf_d;

    // Normalize, round, and resolve overflow/underflow of the finished product
    always_comb begin
        logic                 norm, g, st, lsb, inc, carry, to_inf;
        logic [FRC_W-1:0]     frac_k;
        logic [FRC_W:0]       frac_sum;
        logic signed [XW-1:0] exp_f;

        norm   = acc_q[PROD_W-1];
        frac_k = norm ? acc_q[PROD_W-2 -: FRC_W] : acc_q[PROD_W-3 -: FRC_W];
        g      = norm ? acc_q[SIG_W-1] : acc_q[SIG_W-2];
        st     = norm ? (|acc_q[SIG_W-2:0]) : (|acc_q[SIG_W-3:0]);
        lsb    = frac_k[0];

        case (mode_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_q && (g || st);
            RM_RUP:  inc = !sign_q && (g || st);
            RM_RMM:  inc = g;
            default: inc = g && (st || lsb);
        endcase

        // The hidden bit is always 1, so a carry out of the fraction means
        // the significand rolled over to 10.0...0.
        frac_sum = {1'b0, frac_k} + (FRC_W+1)'(inc);
        carry    = frac_sum[FRC_W];
        exp_f    = XW'(ex_q) + XW'(ey_q) - XW'(BIAS) + XW'(norm) + XW'(carry);

        rnd_unf_d = exp_f[XW-1] || (exp_f == '0);
        rnd_ovf_d = !rnd_unf_d && (exp_f >= EXP_LIM);

        case (mode_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign_q;
            RM_RUP:  to_inf = !sign_q;
            default: to_inf = 1'b1;
        endcase

        if (rnd_unf_d)
            rnd_z_d = {sign_q, {(W-1){1'b0}}};
        else if (rnd_ovf_d)
            rnd_z_d = to_inf ? {sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                             : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
        else
            rnd_z_d = {sign_q, exp_f[EXP_W-1:0], frac_sum[FRC_W-1:0]};
    end

    // Control FSM, Booth iteration and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: only control and visible outputs are reset; datapath registers
        // are always loaded before use, so clearing them would be dead logic.
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fp_z_q      <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
            nv_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= sign_in;
                        ex_q       <= ex_in;
                        ey_q       <= ey_in;
                        mode_q     <= mode_in_d;
                        m_q        <= m_init_d;
                        ybits_q    <= y_init_d;
                        yprev_q    <= 1'b0;
                        acc_q      <= corr_d;
                        cnt_q      <= '0;
                        if (is_special_d) begin
                            fp_z_q      <= sp_z_d;
                            nv_q        <= sp_nv_d;
                            ovrf_q      <= 1'b0;
                            udrf_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q   <= acc_q + pp_d;
                    m_q     <= m_q << 2;
                    ybits_q <= ybits_q >> 2;
                    yprev_q <= ybits_q[1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST)
                        state_q <= S_ROUND;
                end
                S_ROUND: begin
                    fp_z_q      <= rnd_z_d;
                    ovrf_q      <= rnd_ovf_d;
                    udrf_q      <= rnd_unf_d;
                    nv_q        <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign fp_Z      = fp_z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign nv        = nv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq (binary32 defaults).
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_X, fp_Y;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, nv;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_mul_seq #(.EXP_W(8), .FRC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .nv        (nv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present operands at a falling edge; the following rising edge accepts them.
    // Inputs are scrambled afterwards to show the latched copies are used.
    task automatic accept(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] m);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        fp_X     = x;
        fp_Y     = y;
        r_mode   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fp_X     = $urandom;
        fp_Y     = $urandom;
        r_mode   = 3'($urandom_range(0, 7));
    endtask

    // Count falling edges until out_valid is seen, bounded at 40.
    task automatic wait_valid(output int lat, output bit busy_bad);
        lat      = 0;
        busy_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] m, input logic [31:0] ez, input logic [2:0] ef,
                       input int elat);
        int lat;
        bit busy_bad;
        accept(tag, x, y, m);
        wait_valid(lat, busy_bad);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_z"}, 64'(fp_Z), 64'(ez));
        check({tag, "_flags"}, 64'({ovrf, udrf, nv}), 64'(ef));
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        release_result(tag);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int  lat;
        bit  busy_bad;
        bit  bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fp_X      = '0;
        fp_Y      = '0;
        r_mode    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 64'({in_ready, out_valid, fp_Z, ovrf, udrf, nv}),
              64'({1'b1, 1'b0, 32'h0, 3'b000}));

        // Flags are {ovrf, udrf, nv}
        run("three_sq_rtz",   32'h40400000, 32'h40400000, 3'b001, 32'h41100000, 3'b000, 14);
        run("tie_rne",        32'h3F800001, 32'h3FC00000, 3'b000, 32'h3FC00002, 3'b000, 14);
        run("tie_rtz",        32'h3F800001, 32'h3FC00000, 3'b001, 32'h3FC00001, 3'b000, 14);
        run("tie_rup",        32'h3F800001, 32'h3FC00000, 3'b011, 32'h3FC00002, 3'b000, 14);
        run("even_tie_m7",    32'h3F800003, 32'h3FC00000, 3'b111, 32'h3FC00004, 3'b000, 14);
        run("even_tie_rmm",   32'h3F800003, 32'h3FC00000, 3'b100, 32'h3FC00005, 3'b000, 14);
        run("neg_rdn",        32'hBF800001, 32'h3FC00000, 3'b010, 32'hBFC00002, 3'b000, 14);
        run("neg_rup",        32'hBF800001, 32'h3FC00000, 3'b011, 32'hBFC00001, 3'b000, 14);
        run("carry_rup",      32'h3FFFFFFE, 32'h3F800001, 3'b011, 32'h40000000, 3'b000, 14);
        run("carry_rtz",      32'h3FFFFFFE, 32'h3F800001, 3'b001, 32'h3FFFFFFF, 3'b000, 14);
        run("ovf_rne",        32'h7F000000, 32'h7F000000, 3'b000, 32'h7F800000, 3'b100, 14);
        run("ovf_rtz",        32'h7F000000, 32'h7F000000, 3'b001, 32'h7F7FFFFF, 3'b100, 14);
        run("ovf_neg_rup",    32'hFF000000, 32'h7F000000, 3'b011, 32'hFF7FFFFF, 3'b100, 14);
        run("ovf_neg_rdn",    32'hFF000000, 32'h7F000000, 3'b010, 32'hFF800000, 3'b100, 14);
        run("max_finite",     32'h7F000000, 32'h3FFFFFFF, 3'b000, 32'h7F7FFFFF, 3'b000, 14);
        run("ovf_edge",       32'h7F000000, 32'h40000000, 3'b000, 32'h7F800000, 3'b100, 14);
        run("unf_min_sq",     32'h00800000, 32'h00800000, 3'b000, 32'h00000000, 3'b010, 14);
        run("min_normal",     32'h00800000, 32'h3F800000, 3'b000, 32'h00800000, 3'b000, 14);
        run("unf_edge",       32'h00800000, 32'h3F7FFFFF, 3'b000, 32'h00000000, 3'b010, 14);
        run("subnormal",      32'h80000001, 32'h3F800000, 3'b000, 32'h80000000, 3'b000, 1);
        run("inf_times_zero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 3'b001, 1);
        run("nan_operand",    32'h7FC12345, 32'h3F800000, 3'b000, 32'h7FC00000, 3'b001, 1);
        run("nan_neg_signs",  32'hFF800000, 32'hFFC00000, 3'b000, 32'h7FC00000, 3'b001, 1);
        run("inf_finite",     32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 3'b000, 1);
        run("inf_inf",        32'h7F800000, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000, 1);
        run("zero_finite",    32'h00000000, 32'hC0000000, 3'b000, 32'h80000000, 3'b000, 1);

        // Backpressure: result must hold while out_ready stays low
        accept("bp", 32'h40400000, 32'h40400000, 3'b001);
        wait_valid(lat, busy_bad);
        check("bp_lat", 64'(lat), 64'd14);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({fp_Z, out_valid, in_ready, ovrf, udrf, nv} !==
                {32'h41100000, 1'b1, 1'b0, 3'b000}) bad = 1'b1;
        end
        check("bp_hold", 64'(bad), 64'd0);
        release_result("bp");

        // Reset during the fifth MUL cycle aborts the operation
        accept("rst_mid", 32'h3F800001, 32'h3FC00000, 3'b000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 64'({in_ready, out_valid, fp_Z, ovrf, udrf, nv}),
              64'({1'b1, 1'b0, 32'h0, 3'b000}));
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        check("rst_mid_no_valid", 64'(bad), 64'd0);

        // Block recovers after the abort
        run("after_rst", 32'h40400000, 32'h40400000, 3'b000, 32'h41100000, 3'b000, 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
